// File: rtl/smem_bank_scheduler_pkg.sv
// Shared definitions for the shared-memory bank replay scheduler:
// geometry constants, FSM state type and the bank-extraction helper.
package smem_sched_pkg;

   localparam int unsigned LANES    = 32;
   localparam int unsigned BANKS    = 16;
   localparam int unsigned BANK_LOG = $clog2(BANKS);
   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned WARP_W   = 5;
   localparam int unsigned IDX_W    = 6;

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } schedState_t;

   // Word-interleaved banking: byte offset bits [1:0] are dropped,
   // the next BANK_LOG bits select the bank.
   function automatic logic [BANK_LOG-1:0] bankOf(input logic [ADDR_W-1:0] addr);
      return addr[BANK_LOG+1:2];
   endfunction

endpackage

// File: rtl/smem_bank_scheduler_if.sv
// Request/pass bus of the shared-memory bank scheduler.
//   req_*    : warp-wide request from the load/store operand stage
//   pass_*   : one conflict-free pass towards the bank array
//   conflict_o : current request needed more than one pass
// Modports: master drives requests and the stall, slave is the scheduler.
interface smem_bank_scheduler_if
   import smem_sched_pkg::*;
   ();

   logic                    req_valid_i;
   logic                    req_ready_o;
   logic [LANES*ADDR_W-1:0] req_addr_i;
   logic [LANES-1:0]        req_mask_i;
   logic [WARP_W-1:0]       req_warp_i;
   logic                    req_load_i;
   logic                    pass_stall_i;
   logic                    pass_valid_o;
   logic [LANES-1:0]        pass_mask_o;
   logic                    pass_last_o;
   logic [WARP_W-1:0]       pass_warp_o;
   logic                    pass_load_o;
   logic [IDX_W-1:0]        pass_idx_o;
   logic                    conflict_o;

   modport master (
      output req_valid_i, req_addr_i, req_mask_i, req_warp_i, req_load_i,
             pass_stall_i,
      input  req_ready_o, pass_valid_o, pass_mask_o, pass_last_o,
             pass_warp_o, pass_load_o, pass_idx_o, conflict_o
   );

   modport slave (
      input  req_valid_i, req_addr_i, req_mask_i, req_warp_i, req_load_i,
             pass_stall_i,
      output req_ready_o, pass_valid_o, pass_mask_o, pass_last_o,
             pass_warp_o, pass_load_o, pass_idx_o, conflict_o
   );

endinterface

// File: rtl/smem_bank_grant.sv
// Combinational grant selection for one pass.
//   pending : lanes still to be served
//   addrs   : latched per-lane byte addresses, lane i at [i*ADDR_W +: ADDR_W]
//   grant   : lanes served this pass
// Each bank's winner is its lowest-index pending lane; any other pending
// lane in that bank hitting the same word rides along as a broadcast.
module smem_bank_grant
   import smem_sched_pkg::*;
(
   input  logic [LANES-1:0]        pending,
   input  logic [LANES*ADDR_W-1:0] addrs,
   output logic [LANES-1:0]        grant
);

   logic [BANKS-1:0]  found;
   logic [ADDR_W-3:0] winWord [BANKS];

   always_comb begin
      found = '0;
      grant = '0;
      for (int unsigned b = 0; b < BANKS; b++) begin
         winWord[b] = '0;
      end

      // Ascending scan makes the first hit per bank the lowest-index lane.
      for (int unsigned i = 0; i < LANES; i++) begin
         if (pending[i] && !found[bankOf(addrs[i*ADDR_W +: ADDR_W])]) begin
            found[bankOf(addrs[i*ADDR_W +: ADDR_W])]   = 1'b1;
            winWord[bankOf(addrs[i*ADDR_W +: ADDR_W])] = addrs[i*ADDR_W+2 +: ADDR_W-2];
         end
      end

      for (int unsigned i = 0; i < LANES; i++) begin
         if (pending[i] &&
             winWord[bankOf(addrs[i*ADDR_W +: ADDR_W])] == addrs[i*ADDR_W+2 +: ADDR_W-2]) begin
            grant[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/smem_bank_scheduler.sv
// Replay scheduler for the shared-memory load/store path. Accepts one
// warp-wide request, then issues bank-conflict-free passes, one per
// non-stalled cycle, until every active lane has been served.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, aborts any request in flight
//   bus   : request/pass bus (slave side)
module smem_bank_scheduler
   import smem_sched_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   smem_bank_scheduler_if.slave  bus
);

   schedState_t             state;
   logic [LANES-1:0]        pending;
   logic [LANES*ADDR_W-1:0] addrs;
   logic [WARP_W-1:0]       warp;
   logic                    load;
   logic [IDX_W-1:0]        counter;

   logic                    reqReady;
   logic                    passValid;
   logic [LANES-1:0]        passMask;
   logic                    passLast;
   logic [WARP_W-1:0]       passWarp;
   logic                    passLoad;
   logic [IDX_W-1:0]        passIdx;
   logic                    conflict;

   logic [LANES-1:0]        grant;
   logic [LANES-1:0]        remaining;

   smem_bank_grant grantUnit (
      .pending (pending),
      .addrs   (addrs),
      .grant   (grant)
   );

   assign remaining = pending & ~grant;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         pending   <= '0;
         addrs     <= '0;
         warp      <= '0;
         load      <= 1'b0;
         counter   <= '0;
         reqReady  <= 1'b1;
         passValid <= 1'b0;
         passMask  <= '0;
         passLast  <= 1'b0;
         passWarp  <= '0;
         passLoad  <= 1'b0;
         passIdx   <= '0;
         conflict  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // A stalled pass stays presented even while a new request is taken.
               if (!bus.pass_stall_i) begin
                  passValid <= 1'b0;
               end
               if (bus.req_valid_i) begin
                  addrs    <= bus.req_addr_i;
                  pending  <= bus.req_mask_i;
                  warp     <= bus.req_warp_i;
                  load     <= bus.req_load_i;
                  counter  <= '0;
                  conflict <= 1'b0;
                  reqReady <= 1'b0;
                  state    <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (!bus.pass_stall_i) begin
                  passValid <= 1'b1;
                  passMask  <= grant;
                  passLast  <= (remaining == '0);
                  passWarp  <= warp;
                  passLoad  <= load;
                  passIdx   <= counter;
                  pending   <= remaining;
                  counter   <= counter + IDX_W'(1);
                  if (counter == '0) begin
                     conflict <= (remaining != '0);
                  end
                  // An empty mask falls through here too: one pass, mask 0, last.
                  if (remaining == '0) begin
                     reqReady <= 1'b1;
                     state    <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready_o  = reqReady;
   assign bus.pass_valid_o = passValid;
   assign bus.pass_mask_o  = passMask;
   assign bus.pass_last_o  = passLast;
   assign bus.pass_warp_o  = passWarp;
   assign bus.pass_load_o  = passLoad;
   assign bus.pass_idx_o   = passIdx;
   assign bus.conflict_o   = conflict;

endmodule

// File: tb/tb_smem_bank_scheduler.sv
module tb_smem_bank_scheduler;
   import smem_sched_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   smem_bank_scheduler_if bus ();

   smem_bank_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int nCmp  = 0;
   int nFail = 0;

   logic [ADDR_W-1:0] laneAddr [LANES];
   logic [LANES-1:0]  expMasks [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int bankOfLane(input int l);
      return int'((laneAddr[l] >> 2) % BANKS);
   endfunction

   function automatic logic [ADDR_W-1:0] wordOfLane(input int l);
      return laneAddr[l] >> 2;
   endfunction

   // Reference: a pending lane is served in a pass when the lowest-index
   // pending lane of its bank targets the same word.
   task automatic modelBuild(input logic [LANES-1:0] mask);
      logic [LANES-1:0] pend;
      logic [LANES-1:0] g;
      int first;
      pend = mask;
      expMasks.delete();
      do begin
         g = '0;
         for (int i = 0; i < LANES; i++) begin
            if (pend[i]) begin
               first = -1;
               for (int j = 0; j < LANES && first < 0; j++) begin
                  if (pend[j] && bankOfLane(j) == bankOfLane(i)) first = j;
               end
               if (wordOfLane(first) == wordOfLane(i)) g[i] = 1'b1;
            end
         end
         expMasks.push_back(g);
         pend = pend & ~g;
      end while (pend != '0);
   endtask

   task automatic runReq(input logic [LANES-1:0] mask, input logic [WARP_W-1:0] warp,
                         input logic load, input logic [63:0] stallBits,
                         input logic acceptStall, input int abortAfter);
      int n;
      int p;
      int c;
      int guard;
      logic stall;
      modelBuild(mask);
      n = expMasks.size();

      @(negedge clk);
      guard = 0;
      while (bus.req_ready_o !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("readyWait", bus.req_ready_o, 1);

      bus.req_valid_i  = 1'b1;
      bus.req_mask_i   = mask;
      bus.req_warp_i   = warp;
      bus.req_load_i   = load;
      bus.pass_stall_i = acceptStall;
      for (int i = 0; i < LANES; i++) bus.req_addr_i[i*ADDR_W +: ADDR_W] = laneAddr[i];
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      check("acceptReady", bus.req_ready_o, 0);

      p = 0;
      c = 0;
      while (p < n && c < 200) begin
         @(negedge clk);
         stall = (c < 64) ? stallBits[c] : 1'b0;
         bus.pass_stall_i = stall;
         @(posedge clk);
         #1;
         if (!stall) begin
            check("passValid", bus.pass_valid_o, 1);
            check("passMask", bus.pass_mask_o, expMasks[p]);
            check("passIdx", bus.pass_idx_o, p);
            check("passLast", bus.pass_last_o, (p == n - 1));
            check("passWarp", bus.pass_warp_o, warp);
            check("passLoad", bus.pass_load_o, load);
            check("conflict", bus.conflict_o, (n > 1));
            if (abortAfter >= 0 && p == abortAfter) begin
               bus.pass_stall_i = 1'b0;
               return;
            end
            p++;
         end else if (p > 0) begin
            check("holdValid", bus.pass_valid_o, 1);
            check("holdMask", bus.pass_mask_o, expMasks[p-1]);
            check("holdIdx", bus.pass_idx_o, p - 1);
         end
         c++;
      end
      bus.pass_stall_i = 1'b0;
      check("passCount", p, n);
      check("readyBack", bus.req_ready_o, 1);
   endtask

   initial begin
      logic [LANES-1:0] rmask;
      logic [63:0] rstall;
      int mode;
      int stride;
      logic [ADDR_W-1:0] base;

      reset            = 1'b1;
      bus.req_valid_i  = 1'b0;
      bus.req_addr_i   = '0;
      bus.req_mask_i   = '0;
      bus.req_warp_i   = '0;
      bus.req_load_i   = 1'b0;
      bus.pass_stall_i = 1'b0;
      #1;
      check("rstReady", bus.req_ready_o, 1);
      check("rstValid", bus.pass_valid_o, 0);
      check("rstMask", bus.pass_mask_o, 0);
      check("rstIdx", bus.pass_idx_o, 0);
      check("rstConflict", bus.conflict_o, 0);
      @(negedge clk);
      reset = 1'b0;

      // Unit stride, full mask: two passes split on the bank wrap.
      for (int i = 0; i < LANES; i++) laneAddr[i] = 32'(4 * i);
      runReq('1, 5'd3, 1'b1, '0, 1'b0, -1);

      // Broadcast: every lane on one word.
      for (int i = 0; i < LANES; i++) laneAddr[i] = 32'h100;
      runReq('1, 5'd1, 1'b0, '0, 1'b0, -1);

      // Stride 64: all in bank 0, 32 passes.
      for (int i = 0; i < LANES; i++) laneAddr[i] = 32'(64 * i);
      runReq('1, 5'd2, 1'b1, '0, 1'b0, -1);

      // Empty mask.
      runReq('0, 5'd7, 1'b0, '0, 1'b0, -1);

      // Unit stride with a 3-cycle stall after pass 0.
      for (int i = 0; i < LANES; i++) laneAddr[i] = 32'(4 * i);
      runReq('1, 5'd4, 1'b1, 64'b01110, 1'b0, -1);

      // Reset in the middle of a stride-64 request.
      for (int i = 0; i < LANES; i++) laneAddr[i] = 32'(64 * i);
      runReq('1, 5'd9, 1'b0, '0, 1'b0, 5);
      #2;
      reset = 1'b1;
      #1;
      check("midRstValid", bus.pass_valid_o, 0);
      check("midRstReady", bus.req_ready_o, 1);
      check("midRstConflict", bus.conflict_o, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < LANES; i++) laneAddr[i] = 32'(4 * i);
      runReq('1, 5'd11, 1'b1, '0, 1'b0, -1);

      // Randomized requests with random stalls.
      for (int t = 0; t < 24; t++) begin
         mode = int'($urandom_range(0, 2));
         base = $urandom;
         stride = int'($urandom_range(0, 4));
         for (int i = 0; i < LANES; i++) begin
            case (mode)
               0: laneAddr[i] = $urandom;
               1: laneAddr[i] = base + 32'(i * (4 << stride));
               default: laneAddr[i] = 32'($urandom_range(0, 47) * 4 + $urandom_range(0, 3));
            endcase
         end
         rmask  = ($urandom_range(0, 3) == 0) ? '1 : $urandom;
         rstall = {$urandom, $urandom} & {$urandom, $urandom};
         runReq(rmask, 5'($urandom), 1'($urandom), rstall, 1'($urandom), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule

// File: doc/smem_bank_scheduler.md
# smem_bank_scheduler

Replay scheduler for the shared-memory load/store path. It accepts one warp-wide shared-memory request: per-lane byte addresses, active mask, warp id and load/store flag. It splits the request into a sequence of bank-conflict-free passes and issues one pass per cycle to the shared-memory bank array. It sits between the load/store operand stage and the banked shared memory, and holds off upstream issue until every active lane of the current request has been served.

## Interface
Parameters:
- `LANES`, 32, lanes per warp (`SIZE_CORE`).
- `BANKS`, 16, shared-memory banks; power of two.
- `ADDR_W`, 32, per-lane byte address width (`SIZE_ADDR`).
- `WARP_W`, 5, warp id width (`NUM_WARP_LOG`).

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  scheduler can accept a request.
- `req_addr_i`  in  LANES*ADDR_W  lane i address at bits [i*ADDR_W +: ADDR_W].
- `req_mask_i`  in  LANES  active lanes.
- `req_warp_i`  in  WARP_W  warp id.
- `req_load_i`  in  1  1 = load, 0 = store.
- `pass_stall_i`  in  1  downstream cannot take the presented pass.
- `pass_valid_o`  out  1  pass presented.
- `pass_mask_o`  out  LANES  lanes served by this pass.
- `pass_last_o`  out  1  final pass of the request.
- `pass_warp_o`  out  WARP_W  warp id of the request.
- `pass_load_o`  out  1  load flag of the request.
- `pass_idx_o`  out  6  pass number within the request, starting at 0.
- `conflict_o`  out  1  current request needs more than one pass.

## Operation
- Bank of lane i: `addr[BANK_LOG+1:2]`. Word address: `addr[ADDR_W-1:2]`. Byte offset bits [1:0] are ignored.
- Registered state: pending mask, latched addresses, warp, load, state, pass counter.
- FSM states:
  - IDLE: `req_ready_o=1`. On `req_valid_i`, latch the request, set pending = `req_mask_i`, go to BUSY.
  - BUSY: `req_ready_o=0`. Stays in BUSY until the pass that empties pending is issued, then returns to IDLE.
- Grant rule, computed combinationally from pending and the latched addresses. For each bank, the winner is the lowest-index pending lane in that bank. Grant = all winners, plus every pending lane whose word address equals the winner of its bank (broadcast).
- Issue, in BUSY at an edge with `pass_stall_i=0`:
  - `pass_valid_o<=1`, `pass_mask_o<=grant`, `pending<=pending&~grant`.
  - `pass_last_o<=(pending&~grant)==0`.
  - `pass_idx_o<=counter`, then counter increments.
- Empty mask: a request with `req_mask_i=0` issues exactly one pass with mask 0 and `pass_last_o=1`.
- `conflict_o` is set at the first pass when `pending&~grant!=0`. It holds until the next request is accepted.
- Worst case is 32 passes: all lanes in one bank at distinct words. `pass_idx_o` range is 0..31.
- Reset: all outputs 0, except `req_ready_o=1`. Pending and counter are 0, state is IDLE. Asserting reset mid-BUSY aborts the request with no further passes.

## Timing
- Accept at edge k. First pass is registered at edge k+1.
- An N-pass request occupies edges k+1..k+N when there is no stall. `req_ready_o` rises after edge k+N.
- While `pass_stall_i=1`, every pass output, pending and the counter hold. A presented pass counts as consumed only at an edge with the stall low.
- At a non-stalled edge in IDLE with no new issue, `pass_valid_o<=0`.
- A request may be accepted in IDLE while the stall is high. Its first pass waits for the stall to drop.
- Minimum initiation interval is 2 cycles per request.

## Structure
- Package `smem_sched_pkg`: `LANES`, `BANKS`, `BANK_LOG`, the state enum `{S_IDLE,S_BUSY}`, and a bank-extraction function.
- Sub-module `smem_bank_grant`: purely combinational. Inputs are pending and addresses; output is the grant mask. The top module holds the FSM, latches and output registers.

## Test plan
- Unit stride, `addr=4*i`, full mask: 2 passes. Pass 0 is mask 0x0000FFFF with idx 0 and last=0. Pass 1 is mask 0xFFFF0000 with idx 1 and last=1. `conflict_o=1`.
- Broadcast, all lanes at 0x100, full mask: 1 pass, mask 0xFFFFFFFF, last=1, `conflict_o=0`.
- Stride 64 bytes, all lanes in bank 0: 32 passes with masks 1<<0 .. 1<<31 in order. Last is set only on idx 31.
- Mask 0x00000000, warp 7: one pass with mask 0, last=1, `pass_warp_o=7`. `req_ready_o` returns next cycle.
- Unit-stride case with `pass_stall_i` held high for 3 cycles during pass 0: outputs hold at mask 0x0000FFFF. Pass 1 appears one cycle after the stall drops.
- Reset pulse while the stride-64 request is at idx 5: `pass_valid_o=0` and `req_ready_o=1` immediately. After reset releases, a new request runs normally from idx 0.
